// File: rtl/alu_reg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_reg_sequencer_if
// Description : Instruction request / result response handshake bundle for
//               the ALU register-file sequencer.
//               Request : in_valid, in_ready, in_instr[15:0]
//               Response: out_valid, out_ready, out_data[DATA_W:0]
//               modport slave  - the sequencer side
//               modport master - the instruction source / result sink
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_reg_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_instr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W:0]   out_data;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_reg_sequencer
// Description : Control stage for the 8-bit ALU + register-file datapath.
//               Takes one instruction at a time, sequences the register-file
//               reads / ALU / write-back, and returns the 9-bit result on a
//               held valid/ready response.
//               Optional macro ALU_SEQ_ZFLAG_EN adds the zero_flag output.
// Ports       : clk, rst (sync, active-high)
//               bus          - request/response handshake (slave modport)
//               opcode, c_in - ALU control
//               alu_out      - ALU result {carry, data}
//               Read_Addr_1/2, Write_Addr, Data_in, Writr_Enable - reg file
//               carry_flag   - carry from the last ALU instruction
//               zero_flag    - (ALU_SEQ_ZFLAG_EN only) result==0 flag
// Revision    : 1.0 - initial release
// ============================================================================
module alu_reg_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  wire logic              clk,
    input  wire logic              rst,
    alu_reg_sequencer_if.slave     bus,
    output logic [2:0]             opcode,
    output logic                   c_in,
    input  wire logic [DATA_W:0]   alu_out,
    output logic [ADDR_W-1:0]      Read_Addr_1,
    output logic [ADDR_W-1:0]      Read_Addr_2,
    output logic [ADDR_W-1:0]      Write_Addr,
    output logic [DATA_W-1:0]      Data_in,
    output logic                   Writr_Enable,
`ifdef ALU_SEQ_ZFLAG_EN
    output logic                   zero_flag,
`endif
    output logic                   carry_flag
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_dest;
    logic [DATA_W:0]   r_result;
    logic              w_accept;
    logic              w_is_ldi;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_is_ldi = bus.in_instr[15];

    // Bit 0 of an ALU word is reserved and never decoded.
    logic w_unused_bits;
    assign w_unused_bits = bus.in_instr[0];

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_RESP);
    assign bus.out_data  = r_result;
    // Gated by rst so a reset landing in WB kills the write in that cycle.
    assign Writr_Enable  = (r_state == S_WB) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_is_ldi ? S_WB : S_EXEC;
            S_EXEC: w_next = S_WB;
            S_WB:   w_next = S_RESP;
            S_RESP: if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Register-file facing outputs are loaded one edge ahead of the state
    // that uses them so they are stable for the whole active cycle, and
    // otherwise hold their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dest      <= '0;
            r_result    <= '0;
            carry_flag  <= 1'b0;
            opcode      <= 3'd0;
            c_in        <= 1'b0;
            Read_Addr_1 <= '0;
            Read_Addr_2 <= '0;
            Write_Addr  <= '0;
            Data_in     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_ldi) begin
                            Write_Addr <= bus.in_instr[14:12];
                            Data_in    <= bus.in_instr[7:0];
                            r_result   <= {1'b0, bus.in_instr[7:0]};
                        end else begin
                            r_dest      <= bus.in_instr[11:9];
                            opcode      <= bus.in_instr[14:12];
                            Read_Addr_1 <= bus.in_instr[8:6];
                            Read_Addr_2 <= bus.in_instr[5:3];
                            // carry_flag only moves at the end of EXEC, so
                            // sampling it here is the value EXEC would see.
                            c_in        <= bus.in_instr[1] ? carry_flag
                                                           : bus.in_instr[2];
                        end
                    end
                end
                S_EXEC: begin
                    r_result   <= alu_out;
                    carry_flag <= alu_out[DATA_W];
                    Write_Addr <= r_dest;
                    Data_in    <= alu_out[DATA_W-1:0];
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_ZFLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_flag <= 1'b0;
        end else if (r_state == S_EXEC) begin
            zero_flag <= (alu_out[DATA_W-1:0] == '0);
        end
    end
`endif

endmodule
`default_nettype wire
